// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the pipelined doubleword data memory.
package riscv_mem_pkg;

    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    function automatic bit read_lat_ok(input int lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

endpackage

// File: rtl/mem_lat_stage.sv
// One stage of the read-latency pipe: a valid/err/data register that advances when enabled.
module mem_lat_stage
    import riscv_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  rsp_t in_rsp,
    output rsp_t out_rsp
);

    rsp_t stage_d;
    rsp_t stage_q;

    // Bubbles move the valid bit only, so the last real data stays visible on rdata.
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d.valid = in_rsp.valid;
            if (in_rsp.valid) begin
                stage_d.err  = in_rsp.err;
                stage_d.data = in_rsp.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_rsp = stage_q;

endmodule

// File: rtl/data_mem_pipe.sv
// Doubleword data memory with byte-masked writes, a READ_LAT-deep read pipe and
// valid/ready handshakes on both the request and response sides.
module data_mem_pipe
    import riscv_mem_pkg::rsp_t;
    import riscv_mem_pkg::read_lat_ok;
#(
    parameter int DEPTH     = 512,
    parameter int ADDR_WIDE = 29,
    parameter int READ_LAT  = 2,
    parameter int DATA_W    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           addr,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rsp_err,
    output logic                  wr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
        $error("data_mem_pipe: READ_LAT must be in 1..4");
    end
    if (DATA_W != 64) begin : g_bad_width
        $error("data_mem_pipe: DATA_W must be 64");
    end

    logic [ADDR_WIDE-1:0] idx;
    logic [IDX_W-1:0]     mem_idx;
    logic                 oor;
    logic                 stall;
    logic                 advance;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [DATA_W-1:0]    rd_word;
    logic                 wr_err_d;
    logic                 wr_err_q;
    logic                 unused_addr_bits;

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    rsp_t pipe [READ_LAT+1];

    assign unused_addr_bits = ^addr[2:0];

    assign idx     = addr[ADDR_WIDE+2:3];
    assign mem_idx = idx[IDX_W-1:0];
    assign oor     = (idx >= ADDR_WIDE'(DEPTH));

    // A stalled response freezes the whole pipe and blocks writes too, keeping strict order.
    assign stall     = pipe[READ_LAT].valid & ~rsp_ready;
    assign advance   = ~stall;
    assign req_ready = ~stall;

    assign rd_acc = req_valid & req_ready & ~wr_en & ~rst;
    assign wr_acc = req_valid & req_ready &  wr_en & ~rst;

    // Memory is written at the acceptance edge, so a following read needs no forwarding.
    always_ff @(posedge clk) begin
        if (wr_acc && !oor) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wmask[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (!oor) begin
            rd_word = mem_q[mem_idx];
        end
    end

    assign pipe[0] = '{valid: rd_acc, err: oor, data: rd_word};

    for (genvar i = 0; i < READ_LAT; i++) begin : g_stage
        mem_lat_stage u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (advance),
            .in_rsp  (pipe[i]),
            .out_rsp (pipe[i+1])
        );
    end

    assign wr_err_d = wr_acc & oor;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign rsp_valid = pipe[READ_LAT].valid;
    assign rsp_err   = pipe[READ_LAT].err;
    assign rdata     = pipe[READ_LAT].data;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: table-driven vectors plus stall and reset sequences.
module tb_data_mem_pipe;

    localparam int DEPTH    = 512;
    localparam int READ_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        wr_en;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rdata;
    logic        rsp_err;
    logic        wr_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_pipe #(
        .DEPTH     (DEPTH),
        .ADDR_WIDE (29),
        .READ_LAT  (READ_LAT),
        .DATA_W    (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .wmask     (wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .rsp_err   (rsp_err),
        .wr_err    (wr_err)
    );

    typedef struct {
        logic        rv;
        logic        we;
        logic [31:0] a;
        logic [63:0] wd;
        logic [7:0]  wm;
        logic        rr;
        logic        ev;
        logic [63:0] ed;
        logic        ee;
        logic        ewe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rv, input logic we, input logic [31:0] a,
                                input logic [63:0] wd, input logic [7:0] wm,
                                input logic ev, input logic [63:0] ed,
                                input logic ee, input logic ewe);
        vec_t v;
        v.rv = rv; v.we = we; v.a = a; v.wd = wd; v.wm = wm; v.rr = 1'b1;
        v.ev = ev; v.ed = ed; v.ee = ee; v.ewe = ewe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic we, input logic [31:0] a,
                         input logic [63:0] wd, input logic [7:0] wm, input logic rr);
        req_valid = rv;
        wr_en     = we;
        addr      = a;
        wdata     = wd;
        wmask     = wm;
        rsp_ready = rr;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_q[$];
    int          issued;
    int          popped;
    int          stall_cnt;
    logic        rr_b;

    initial begin
        // Rows: one cycle each; expectations are the outputs seen during that cycle.
        tbl.push_back(mk(1, 1, 32'h10, 64'h1122334455667788, 8'h0F, 0, 64'h0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h10, 64'h0, 8'h00, 0, 64'h0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 0, 64'h0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 1, 64'h0000000055667788, 0, 0));
        tbl.push_back(mk(1, 1, 32'h00, 64'hA0, 8'hFF, 0, 64'h0000000055667788, 0, 0));
        tbl.push_back(mk(1, 1, 32'h08, 64'hA1, 8'hFF, 0, 64'h0000000055667788, 0, 0));
        tbl.push_back(mk(1, 1, 32'h10, 64'hA2, 8'hFF, 0, 64'h0000000055667788, 0, 0));
        tbl.push_back(mk(1, 1, 32'h18, 64'hA3, 8'hFF, 0, 64'h0000000055667788, 0, 0));
        tbl.push_back(mk(1, 0, 32'h00, 64'h0, 8'h00, 0, 64'h0000000055667788, 0, 0));
        tbl.push_back(mk(1, 0, 32'h08, 64'h0, 8'h00, 0, 64'h0000000055667788, 0, 0));
        tbl.push_back(mk(1, 0, 32'h10, 64'h0, 8'h00, 1, 64'hA0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h18, 64'h0, 8'h00, 1, 64'hA1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 1, 64'hA2, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 1, 64'hA3, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 0, 64'hA3, 0, 0));
        tbl.push_back(mk(1, 0, DEPTH*8, 64'h0, 8'h00, 0, 64'hA3, 0, 0));
        tbl.push_back(mk(1, 1, DEPTH*8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 64'hA3, 0, 0));
        tbl.push_back(mk(1, 0, 32'h00, 64'h0, 8'h00, 1, 64'h0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 0, 64'h0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 1, 64'hA0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 64'h0, 8'h00, 0, 64'hA0, 0, 0));

        // Reset held three cycles with a request pending.
        rst = 1'b1;
        drive(1, 0, 32'h0, 64'h0, 8'h00, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 32'h0, 64'h0, 8'h00, 1);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rdata", rdata, 64'd0);
        for (int j = 0; j < 3; j++) begin
            next();
            #1;
            chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            next();
            drive(tbl[i].rv, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].wm, tbl[i].rr);
            #1;
            chk($sformatf("row%0d_rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].ev));
            chk($sformatf("row%0d_rdata", i), rdata, tbl[i].ed);
            if (tbl[i].ev) chk($sformatf("row%0d_rsp_err", i), 64'(rsp_err), 64'(tbl[i].ee));
            chk($sformatf("row%0d_wr_err", i), 64'(wr_err), 64'(tbl[i].ewe));
            chk($sformatf("row%0d_req_ready", i), 64'(req_ready), 64'd1);
        end

        // Read burst of words 0..3 with the consumer stalled for cycles 3..7.
        issued = 0; popped = 0; stall_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            next();
            rr_b = !(k >= 3 && k <= 7);
            if (issued < 4) drive(1, 0, 32'(issued * 8), 64'h0, 8'h00, rr_b);
            else            drive(0, 0, 32'h0, 64'h0, 8'h00, rr_b);
            #1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    chk("bp_rdata", rdata, exp_q[0]);
                    if (rr_b) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end else begin
                        chk("bp_req_ready", 64'(req_ready), 64'd0);
                        stall_cnt++;
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(64'hA0 + 64'(issued));
                issued++;
            end
        end
        chk("bp_issued", 64'(issued), 64'd4);
        chk("bp_popped", 64'(popped), 64'd4);
        chk("bp_stall_cycles", 64'(stall_cnt), 64'd5);
        chk("bp_leftover", 64'(exp_q.size()), 64'd0);

        // Reset one cycle after a read is accepted drops it; memory keeps the write.
        next(); drive(1, 1, 32'h28, 64'h55, 8'hFF, 1); #1;
        next(); drive(1, 0, 32'h28, 64'h0, 8'h00, 1); #1;
        next(); rst = 1'b1; drive(0, 0, 32'h0, 64'h0, 8'h00, 1); #1;
        next(); rst = 1'b0; #1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                next();
                #1;
            end
            chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        next(); drive(1, 0, 32'h28, 64'h0, 8'h00, 1); #1;
        next(); drive(0, 0, 32'h0, 64'h0, 8'h00, 1); #1;
        next(); #1;
        chk("mid_rst_reread_valid", 64'(rsp_valid), 64'd1);
        chk("mid_rst_reread_data", rdata, 64'h55);

        // Reset while a response is stalled.
        next(); drive(1, 0, 32'h28, 64'h0, 8'h00, 0); #1;
        next(); drive(0, 0, 32'h0, 64'h0, 8'h00, 0); #1;
        next(); #1;
        chk("stall_rst_valid", 64'(rsp_valid), 64'd1);
        chk("stall_rst_ready0", 64'(req_ready), 64'd0);
        next(); rst = 1'b1; #1;
        chk("stall_rst_still", 64'(req_ready), 64'd0);
        chk("stall_rst_data", rdata, 64'h55);
        next(); rst = 1'b0; #1;
        chk("stall_rst_cleared", 64'(rsp_valid), 64'd0);
        chk("stall_rst_ready1", 64'(req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
